// File: rtl/encoder_32_5_serializer_if.sv
// ============================================================================
// encoder_32_5_serializer_if : request-load and encoded-index beat bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface encoder_32_5_serializer_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ENCODED_WIDTH = $clog2(DATA_WIDTH)
);
  logic                     Enable_In;
  logic                     Load_In;
  logic [DATA_WIDTH-1:0]    Data_In;
  logic                     Load_Ready_Out;
  logic [ENCODED_WIDTH-1:0] Encoded_Value_Out;
  logic                     Valid_Out;
  logic                     Ready_In;
  logic                     Last_Out;
  logic                     Zero_Out;
  logic [ENCODED_WIDTH:0]   Count_Out;

  modport slave (
    input  Enable_In, Load_In, Data_In, Ready_In,
    output Load_Ready_Out, Encoded_Value_Out, Valid_Out, Last_Out, Zero_Out, Count_Out
  );

  modport master (
    output Enable_In, Load_In, Data_In, Ready_In,
    input  Load_Ready_Out, Encoded_Value_Out, Valid_Out, Last_Out, Zero_Out, Count_Out
  );
endinterface

`default_nettype wire

// File: rtl/encoder_32_5_serializer.sv
// ============================================================================
// encoder_32_5_serializer : multi-hot vector to serial stream of set-bit indices
// Optional: ENCODER_MSB_FIRST_EN reverses scan order (highest index first).
// Rev 1.0
// ============================================================================
`default_nettype none

module encoder_32_5_serializer #(
  parameter int DATA_WIDTH    = 32,
  parameter int ENCODED_WIDTH = $clog2(DATA_WIDTH)
) (
  input  wire                       Clock_In,
  input  wire                       Reset_In,
  encoder_32_5_serializer_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    pending_q, pending_d;
  logic [ENCODED_WIDTH-1:0] enc_q, enc_d;
  logic [ENCODED_WIDTH:0]   count_q, count_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic                     zero_q, zero_d;
  logic                     ready_q, ready_d;
  logic                     w_accept;
  logic                     w_emit;

  function automatic logic [ENCODED_WIDTH:0] popcount(input logic [DATA_WIDTH-1:0] v);
    popcount = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      popcount = popcount + {{ENCODED_WIDTH{1'b0}}, v[i]};
    end
  endfunction

  // The last assignment in the loop wins, so loop direction selects priority.
  function automatic logic [ENCODED_WIDTH-1:0] scan_index(input logic [DATA_WIDTH-1:0] v);
    scan_index = '0;
`ifdef ENCODER_MSB_FIRST_EN
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (v[i]) scan_index = ENCODED_WIDTH'(i);
    end
`else
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (v[i]) scan_index = ENCODED_WIDTH'(i);
    end
`endif
  endfunction

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    w_accept  = bus.Enable_In & valid_q & bus.Ready_In;

    case (state_q)
      ST_IDLE: begin
        if (bus.Enable_In && bus.Load_In) begin
          pending_d = bus.Data_In;
          count_d   = popcount(bus.Data_In);
          state_d   = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (w_accept) begin
          if (last_q) begin
            pending_d = '0;
            state_d   = ST_IDLE;
          end else begin
            pending_d = pending_q & ~(DATA_WIDTH'(1) << enc_q);
          end
        end
      end
      default: begin
        pending_d = '0;
        state_d   = ST_IDLE;
      end
    endcase

    // Outputs are precomputed from the next pending vector so they register cleanly.
    w_emit  = (state_d == ST_EMIT);
    valid_d = w_emit;
    ready_d = ~w_emit;
    enc_d   = w_emit ? scan_index(pending_d) : '0;
    zero_d  = w_emit && (pending_d == '0);
    last_d  = w_emit && ((pending_d & (pending_d - DATA_WIDTH'(1))) == '0);
  end

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      enc_q     <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      zero_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      enc_q     <= enc_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      zero_q    <= zero_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.Load_Ready_Out    = ready_q;
  assign bus.Encoded_Value_Out = enc_q;
  assign bus.Valid_Out         = valid_q;
  assign bus.Last_Out          = last_q;
  assign bus.Zero_Out          = zero_q;
  assign bus.Count_Out         = count_q;

endmodule

`default_nettype wire
